latch_sequencer: RTL

//  Parametrised successor of the single-shot CLE/ALE latch: issues a complete NAND command/address

---
 rtl/latch_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/latch_sequencer.sv
// latch_sequencer
//   Issues a complete NAND command/address cycle train (e.g. 00h + address
//   bytes + 30h) from a byte stream, one valid/ready handshake per byte.
//   Sits between the controller FSM and the ONFI pad mux and drives CLE, ALE,
//   nWE and DQ with programmable nWE low/high and CLE/ALE hold times.
//
// Parameters
//   DQ_W      DQ bus width (8 or 16); bytes are zero-extended on 16.
//   MAX_BYTES maximum bytes per train; the last byte is forced at this count.
//   T_WP      nWE low cycles (>=1).
//   T_WH      minimum nWE high cycles between bytes (>=1).
//   T_CLH     CLE/DQ hold cycles after nWE rises on a command byte (>=1).
//   T_ALH     ALE/DQ hold cycles after nWE rises on an address byte (>=1).
//   INIT_CYC  power-up cycles before initialized=1.
//
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   in_valid/in_ready    byte handshake
//   in_data, in_is_cmd   byte and its type (1 = command/CLE, 0 = address/ALE)
//   in_last              final byte of the train
//   cle, ale, nwe        NAND strobes (nwe active low)
//   dq_out, dq_oe        DQ data and output enable
//   busy                 train in progress or power-up count running
//   done                 one-cycle pulse at the end of a train
//   initialized          power-up count finished
//   err                  (LATCH_SEQ_ERR_EN only) overlong train or GAP stall
//
// Build option
//   LATCH_SEQ_ERR_EN: adds the err output. Overlong trains and a stall of more
//   than 255 cycles in GAP abort the train to IDLE instead of forcing last /
//   waiting forever.
//
// All outputs are registers loaded from the next-state decode, so an output
// changes on the same edge as the state it belongs to.
module latch_sequencer #(
  parameter int DQ_W      = 8,
  parameter int MAX_BYTES = 8,
  parameter int T_WP      = 2,
  parameter int T_WH      = 2,
  parameter int T_CLH     = 3,
  parameter int T_ALH     = 3,
  parameter int INIT_CYC  = 15
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic            in_is_cmd,
  input  logic            in_last,
  output logic            cle,
  output logic            ale,
  output logic            nwe,
  output logic [DQ_W-1:0] dq_out,
  output logic            dq_oe,
  output logic            busy,
  output logic            done,
`ifdef LATCH_SEQ_ERR_EN
  output logic            err,
`endif
  output logic            initialized
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = imax(imax(imax(T_WP, T_WH), imax(T_CLH, T_ALH)), INIT_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(MAX_BYTES + 1);

  localparam logic [CW-1:0] INIT_M1 = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] WP_M1   = CW'(T_WP - 1);
  localparam logic [CW-1:0] CLH_M1  = CW'(T_CLH - 1);
  localparam logic [CW-1:0] ALH_M1  = CW'(T_ALH - 1);
  localparam logic [CW-1:0] WH_C    = CW'(T_WH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
`ifdef LATCH_SEQ_ERR_EN
  localparam logic [BW-1:0] BMAX    = BW'(MAX_BYTES);
`else
  localparam logic [BW-1:0] BMAX_M1 = BW'(MAX_BYTES - 1);
`endif

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_WP    = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // INIT / WP / HOLD cycle counter
  logic [CW-1:0]   hi_q, hi_d;       // cycles since nWE rose, saturating at T_WH
  logic [BW-1:0]   bcnt_q, bcnt_d;   // bytes accepted in this train
  logic [7:0]      byte_q, byte_d;
  logic            cmd_q, cmd_d;
  logic            last_q, last_d;
  logic            sw_q, sw_d;       // type-change gap cycle pending
  logic            cle_q, cle_d, ale_q, ale_d, nwe_q, nwe_d;
  logic [DQ_W-1:0] dq_q, dq_d;
  logic            oe_q, oe_d, rdy_q, rdy_d, busy_q, busy_d;
  logic            done_q, done_d, init_q, init_d;
`ifdef LATCH_SEQ_ERR_EN
  logic            err_q, err_d;
  logic [7:0]      stall_q, stall_d;
`endif

  logic            accept_s;
  logic [CW-1:0]   hold_m1_s;
  logic [CW-1:0]   hi_inc_s;

  // Next-state decode followed by the registered-output decode of state_d.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    bcnt_d   = bcnt_q;
    byte_d   = byte_q;
    cmd_d    = cmd_q;
    last_d   = last_q;
    sw_d     = sw_q;
`ifdef LATCH_SEQ_ERR_EN
    err_d    = err_q;
    stall_d  = (state_q == S_GAP && !sw_q && !in_valid) ? stall_q + 8'd1 : 8'd0;
`endif
    accept_s  = in_valid && rdy_q;
    hold_m1_s = cmd_q ? CLH_M1 : ALH_M1;
    hi_inc_s  = (hi_q >= WH_C) ? hi_q : hi_q + 1'b1;

    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (accept_s) begin
          byte_d  = in_data;
          cmd_d   = in_is_cmd;
          bcnt_d  = bcnt_q + 1'b1;
          state_d = S_SETUP;
`ifdef LATCH_SEQ_ERR_EN
          last_d  = in_last;
          err_d   = 1'b0;
`else
          last_d  = in_last || (bcnt_q == BMAX_M1);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_WP;
        cnt_d   = '0;
      end
      S_WP: begin
        if (cnt_q == WP_M1) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          hi_d    = ONE_C;      // first cycle with nWE high
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        hi_d = hi_inc_s;
        if (cnt_q == hold_m1_s) begin
          cnt_d   = '0;
          state_d = last_q ? S_DONE : S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        hi_d = hi_inc_s;
        if (sw_q) begin
          sw_d    = 1'b0;
          state_d = S_SETUP;
        end else if (accept_s) begin
          byte_d = in_data;
          cmd_d  = in_is_cmd;
          bcnt_d = bcnt_q + 1'b1;
`ifdef LATCH_SEQ_ERR_EN
          last_d = in_last;
`else
          last_d = in_last || (bcnt_q == BMAX_M1);
`endif
          // A type change inserts one cycle with both CLE and ALE low.
          if (in_is_cmd != cmd_q) begin
            sw_d = 1'b1;
          end else begin
            state_d = S_SETUP;
          end
`ifdef LATCH_SEQ_ERR_EN
          if (bcnt_q == BMAX) begin
            err_d   = 1'b1;
            sw_d    = 1'b0;
            bcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            err_d = 1'b0;
          end
`endif
        end
`ifdef LATCH_SEQ_ERR_EN
        else if (!in_valid && (stall_q == 8'hFF)) begin
          err_d   = 1'b1;
          bcnt_d  = '0;
          state_d = S_IDLE;
        end
`endif
        else begin
          state_d = S_GAP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    cle_d  = 1'b0;
    ale_d  = 1'b0;
    nwe_d  = 1'b1;
    dq_d   = '0;
    oe_d   = 1'b0;
    rdy_d  = 1'b0;
    busy_d = 1'b1;
    done_d = 1'b0;
    init_d = (state_d != S_INIT);
    case (state_d)
      S_IDLE: begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_SETUP, S_HOLD: begin
        cle_d = cmd_d;
        ale_d = !cmd_d;
        oe_d  = 1'b1;
        dq_d  = DQ_W'(byte_d);
      end
      S_WP: begin
        cle_d = cmd_d;
        ale_d = !cmd_d;
        nwe_d = 1'b0;
        oe_d  = 1'b1;
        dq_d  = DQ_W'(byte_d);
      end
      S_GAP: begin
        oe_d  = 1'b1;
        dq_d  = DQ_W'(byte_d);
        rdy_d = !sw_d && (hi_d >= WH_C);
        if (sw_d) begin
          cle_d = 1'b0;
          ale_d = 1'b0;
        end else begin
          cle_d = cmd_d;
          ale_d = !cmd_d;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset forces every output idle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      hi_q    <= '0;
      bcnt_q  <= '0;
      byte_q  <= 8'd0;
      cmd_q   <= 1'b0;
      last_q  <= 1'b0;
      sw_q    <= 1'b0;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      nwe_q   <= 1'b1;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
`ifdef LATCH_SEQ_ERR_EN
      err_q   <= 1'b0;
      stall_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      bcnt_q  <= bcnt_d;
      byte_q  <= byte_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      sw_q    <= sw_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
      nwe_q   <= nwe_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      init_q  <= init_d;
`ifdef LATCH_SEQ_ERR_EN
      err_q   <= err_d;
      stall_q <= stall_d;
`endif
    end
  end

  assign cle         = cle_q;
  assign ale         = ale_q;
  assign nwe         = nwe_q;
  assign dq_out      = dq_q;
  assign dq_oe       = oe_q;
  assign in_ready    = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign initialized = init_q;
`ifdef LATCH_SEQ_ERR_EN
  assign err         = err_q;
`endif

endmodule
